// File: rtl/spi_status_tx.sv
// spi_status_tx: SPI mode-0 slave transmitter returning tagged 16-bit status words.
// Optional CRC word W3 enabled by defining SPI_STATUS_TX_CRC_EN.
module spi_status_tx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk50M,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_cs_n,
  output logic        spi_miso,
  input  logic [10:0] angle_current,
  input  logic [10:0] angle_target,
  input  logic        m_en,
  input  logic        dir,
  input  logic        dev_state,
  output logic        word_sent,
  output logic        tx_busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

`ifdef SPI_STATUS_TX_CRC_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sck_q;
  logic                   cs_q;
  logic                   sck_s;
  logic                   cs_s;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  logic [1:0]  state;
  logic [1:0]  word_idx;
  logic [4:0]  bit_cnt;
  logic [15:0] shreg;

  logic [10:0] snap_cur;
  logic [10:0] snap_tgt;
  logic        snap_m_en;
  logic        snap_dir;
  logic        snap_dev_state;
  logic        snap_at_target;

  logic        take_snap;
  logic        live_at_target;
  logic [10:0] src_cur;
  logic [10:0] src_tgt;
  logic        src_m_en;
  logic        src_dir;
  logic        src_dev_state;
  logic        src_at_target;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [7:0]  d2;
  logic [15:0] tx_word;
  logic [1:0]  next_idx;

  // Bring SCK and CS into the clk50M domain; CS chain resets low so a
  // frame already running at reset release is never seen as a start.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      cs_sync  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
    end
  end

  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign cs_s  = cs_sync[SYNC_STAGES-1];

  // Previous synchronized levels for edge detection.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      sck_q <= 1'b0;
      cs_q  <= 1'b0;
    end else begin
      sck_q <= sck_s;
      cs_q  <= cs_s;
    end
  end

  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign cs_fall  = ~cs_s & cs_q;
  assign cs_rise  = cs_s & ~cs_q;

  assign take_snap      = (state == ST_LOAD) && (word_idx == 2'd0);
  assign live_at_target = (angle_current == angle_target);

  // Word 0 is built from live inputs (the values being captured this
  // cycle); later words read the held snapshot.
  always_comb begin
    src_cur       = snap_cur;
    src_tgt       = snap_tgt;
    src_m_en      = snap_m_en;
    src_dir       = snap_dir;
    src_dev_state = snap_dev_state;
    src_at_target = snap_at_target;
    if (word_idx == 2'd0) begin
      src_cur       = angle_current;
      src_tgt       = angle_target;
      src_m_en      = m_en;
      src_dir       = dir;
      src_dev_state = dev_state;
      src_at_target = live_at_target;
    end
  end

  assign d0 = src_cur[10:3];
  assign d1 = {src_cur[2:0], src_dev_state, src_m_en,
               src_dir, src_at_target, 1'b0};
  assign d2 = src_tgt[10:3];

  // Select the tagged word for the current sequence position.
  always_comb begin
    tx_word = {8'h10, d0};
    unique case (word_idx)
      2'd0: tx_word = {8'h10, d0};
      2'd1: tx_word = {8'h11, d1};
      2'd2: tx_word = {8'h12, d2};
`ifdef SPI_STATUS_TX_CRC_EN
      2'd3: tx_word = {8'h13, d0 ^ d1 ^ d2};
`else
      2'd3: tx_word = {8'h10, d0};
`endif
    endcase
  end

  assign next_idx = (word_idx == LAST_IDX) ? 2'd0 : word_idx + 2'd1;

  // Capture the status set once per sequence, at the start of word 0.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      snap_cur       <= '0;
      snap_tgt       <= '0;
      snap_m_en      <= 1'b0;
      snap_dir       <= 1'b0;
      snap_dev_state <= 1'b0;
      snap_at_target <= 1'b0;
    end else if (take_snap) begin
      snap_cur       <= angle_current;
      snap_tgt       <= angle_target;
      snap_m_en      <= m_en;
      snap_dir       <= dir;
      snap_dev_state <= dev_state;
      snap_at_target <= live_at_target;
    end
  end

  // Frame sequencer: load, shift on SCK falls, count SCK rises.
  // CS rise wins over any SCK edge seen in the same cycle.
  always_ff @(posedge clk50M or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_idx  <= 2'd0;
      bit_cnt   <= 5'd0;
      shreg     <= 16'd0;
      spi_miso  <= 1'b0;
      word_sent <= 1'b0;
    end else begin
      word_sent <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cs_rise) begin
            spi_miso <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            shreg    <= tx_word;
            spi_miso <= tx_word[15];
            bit_cnt  <= 5'd0;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            spi_miso <= 1'b0;
            state    <= ST_IDLE;
          end else if (sck_rise) begin
            bit_cnt <= bit_cnt + 5'd1;
            if (bit_cnt == 5'd15) begin
              word_sent <= 1'b1;
              word_idx  <= next_idx;
              spi_miso  <= 1'b0;
              state     <= ST_DONE;
            end
          end else if (sck_fall && (bit_cnt < 5'd16)) begin
            shreg    <= {shreg[14:0], 1'b0};
            spi_miso <= shreg[14];
          end
        end
        ST_DONE: begin
          spi_miso <= 1'b0;
          if (cs_rise) state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_busy = (state == ST_LOAD) || (state == ST_SHIFT);

endmodule

// File: tb/tb_spi_status_tx.sv
// tb_spi_status_tx: randomized SPI master with scoreboard for spi_status_tx.
// Expected words come from a word-level model of the status sequence.
module tb_spi_status_tx;

`ifdef SPI_STATUS_TX_CRC_EN
  localparam int NW = 4;
`else
  localparam int NW = 3;
`endif

  logic        clk50M = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_miso;
  logic [10:0] angle_current = '0;
  logic [10:0] angle_target = '0;
  logic        m_en = 1'b0;
  logic        dir = 1'b0;
  logic        dev_state = 1'b0;
  logic        word_sent;
  logic        tx_busy;

  spi_status_tx #(.SYNC_STAGES(2)) dut (
    .clk50M(clk50M),
    .rst(rst),
    .spi_sck(spi_sck),
    .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso),
    .angle_current(angle_current),
    .angle_target(angle_target),
    .m_en(m_en),
    .dir(dir),
    .dev_state(dev_state),
    .word_sent(word_sent),
    .tx_busy(tx_busy)
  );

  always #10 clk50M = ~clk50M;

  typedef struct {
    logic [15:0] word;
    int          nclk;
    int          zero_from;
    int          ws;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int ws_cnt = 0;

  int m_idx = 0;
  int s_cur = 0, s_tgt = 0, s_men = 0, s_dir = 0, s_dev = 0;

  always @(posedge clk50M)
    if (word_sent === 1'b1) ws_cnt <= ws_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_word(input int idx);
    int d0, d1, d2, w;
    d0 = s_cur / 8;
    d1 = (s_cur % 8) * 32 + s_dev * 16 + s_men * 8 + s_dir * 4
       + ((s_cur == s_tgt) ? 2 : 0);
    d2 = s_tgt / 8;
    case (idx)
      0: w = 'h1000 + d0;
      1: w = 'h1100 + d1;
      2: w = 'h1200 + d2;
      default: w = 'h1300 + (d0 ^ d1 ^ d2);
    endcase
    return w[15:0];
  endfunction

  // One chip-select frame of n SCK clocks; rst_at >= 0 pulses reset
  // just before that SCK rise.
  task automatic frame(input int n, input int rst_at);
    exp_t e;
    logic [15:0] w;
    if (m_idx == 0) begin
      s_cur = int'(angle_current);
      s_tgt = int'(angle_target);
      s_men = int'(m_en);
      s_dir = int'(dir);
      s_dev = int'(dev_state);
    end
    w = model_word(m_idx);
    e.word = w;
    e.nclk = n;
    e.zero_from = (rst_at >= 0) ? rst_at : 16;
    e.ws = (rst_at < 0 && n >= 16) ? 1 : 0;
    sb.push_back(e);
    if (rst_at >= 0) m_idx = 0;
    else if (n >= 16) m_idx = (m_idx + 1) % NW;

    @(negedge clk50M);
    spi_cs_n = 1'b0;
    repeat (4) @(posedge clk50M);
    #1;
    chk("start_miso", int'(spi_miso), int'(w[15]));
    chk("start_busy", int'(tx_busy), 1);
    repeat (3) @(negedge clk50M);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_miso", int'(spi_miso), 0);
        chk("rst_busy", int'(tx_busy), 0);
        @(negedge clk50M);
        rst = 1'b0;
        @(negedge clk50M);
      end
      spi_sck = 1'b1;
      repeat (5) @(negedge clk50M);
      spi_sck = 1'b0;
      repeat (5) @(negedge clk50M);
    end
    spi_cs_n = 1'b1;
    repeat (10) @(negedge clk50M);
  endtask

  // Monitor: collect MISO at every SCK rise inside a frame, then
  // compare against the next scoreboard entry.
  initial begin : monitor
    int nb, got, want, ws0, b;
    exp_t e;
    forever begin
      @(negedge spi_cs_n);
      nb = 0;
      got = 0;
      ws0 = ws_cnt;
      while (spi_cs_n === 1'b0) begin
        @(posedge spi_sck or posedge spi_cs_n);
        if (spi_cs_n === 1'b0) begin
          got = (got << 1) | int'(spi_miso);
          nb++;
        end
      end
      repeat (6) @(posedge clk50M);
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: frame with no expectation at %0t",
                 $time);
      end else begin
        e = sb.pop_front();
        want = 0;
        for (int i = 0; i < nb; i++) begin
          b = (i < 16 && i < e.zero_from) ? int'(e.word[15-i]) : 0;
          want = (want << 1) | b;
        end
        chk("frame_nbits", nb, e.nclk);
        chk("frame_bits", got, want);
        chk("word_sent_cnt", ws_cnt - ws0, e.ws);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int r, n;
    repeat (5) @(negedge clk50M);
    #1;
    chk("reset_miso", int'(spi_miso), 0);
    chk("reset_busy", int'(tx_busy), 0);
    chk("reset_ws", int'(word_sent), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk50M);
    chk("idle_miso", int'(spi_miso), 0);

    angle_current = 11'd1234;
    angle_target  = 11'd1234;
    m_en = 1'b1;
    dir = 1'b0;
    dev_state = 1'b1;
    for (int k = 0; k < NW; k++) frame(16, -1);

    frame(16, -1);
    angle_target = 11'd0;
    for (int k = 1; k < NW; k++) frame(16, -1);
    frame(16, -1);
    angle_target = 11'd1234;
    for (int k = 1; k < NW; k++) frame(16, -1);

    frame(16, -1);
    frame(9, -1);
    frame(16, -1);
    frame(20, -1);
    while (m_idx != 0) frame(16, -1);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        angle_current = 11'($urandom_range(0, 2047));
        angle_target = ($urandom_range(0, 2) == 0) ? angle_current
                     : 11'($urandom_range(0, 2047));
        m_en = 1'($urandom_range(0, 1));
        dir = 1'($urandom_range(0, 1));
        dev_state = 1'($urandom_range(0, 1));
      end
      r = $urandom_range(0, 5);
      if (r == 3) n = $urandom_range(1, 15);
      else if (r == 4) n = $urandom_range(17, 20);
      else n = 16;
      frame(n, -1);
    end

    while (m_idx != 2) frame(16, -1);
    frame(12, 5);
    frame(16, -1);
    frame(16, -1);

    repeat (20) @(negedge clk50M);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_status_tx.md
# spi_status_tx

SPI-slave transmit side for the motor positioner: returns position and drive status to the SPI master as tagged 16-bit words (upper byte tag, lower byte data), the same word format used for incoming commands. Sits beside the command receiver and positioner in the `clk50M` domain. Samples the positioner's live status and shifts it out on MISO in SPI mode 0, MSB first, one word per chip-select frame.

## Interface
Parameters:
- `SYNC_STAGES`, 2 — synchronizer depth for `spi_sck` / `spi_cs_n` (minimum 2).

Ports:
- `clk50M`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_sck`  in  1  SPI clock from the master, asynchronous to `clk50M`.
- `spi_cs_n`  in  1  chip select from the master, active low, asynchronous to `clk50M`.
- `spi_miso`  out  1  serial data to the master.
- `angle_current`  in  11  current angle from the positioner.
- `angle_target`  in  11  target angle from the positioner.
- `m_en`  in  1  motor enable, as driven.
- `dir`  in  1  motor direction, as driven.
- `dev_state`  in  1  0 = init, 1 = positioning.
- `word_sent`  out  1  one-cycle pulse when a full 16-bit word has been clocked out.
- `tx_busy`  out  1  high while a frame is in progress (state LOAD or SHIFT).

## Operation
- Both `spi_sck` and `spi_cs_n` pass through `SYNC_STAGES` flip-flops. Edges are detected on the synchronized signals: SCK rise/fall, CS fall (frame start), CS rise (frame end).
- Word sequence, selected by `word_idx` (wraps):
  - W0 = `{8'h10, snap_cur[10:3]}`.
  - W1 = `{8'h11, snap_cur[2:0], snap_dev_state, snap_m_en, snap_dir, snap_at_target, 1'b0}`.
  - W2 = `{8'h12, snap_tgt[10:3]}`.
  - W3 (only with the CRC option, see Configuration).
- `snap_at_target` = (`angle_current` == `angle_target`).
- Snapshot: all status inputs are registered into `snap_*` only when a frame starts with `word_idx`==0. W1..Wn therefore report the same instant as W0.
- State machine:
  - IDLE: `spi_miso`=0. On CS fall → LOAD.
  - LOAD (1 cycle):
    - Take the snapshot if `word_idx`==0.
    - Load the 16-bit shift register with word `word_idx`, built from the freshly captured values.
    - Drive `spi_miso` = bit 15; `bit_cnt`=0.
    - → SHIFT.
  - SHIFT:
    - On SCK rise: `bit_cnt`++.
    - On SCK fall with `bit_cnt`<16: shift left, drive the next bit.
    - When `bit_cnt` reaches 16: pulse `word_sent`, advance `word_idx` (wrap at last word) → DONE.
  - DONE: `spi_miso`=0. Extra SCK edges are ignored. On CS rise → IDLE.
- Abort: CS rise in LOAD or SHIFT → IDLE, no `word_sent`, `word_idx` unchanged. The same word is resent in the next frame; if `word_idx`==0 a new snapshot is taken.
- CS fall while not in IDLE is impossible without an intervening CS rise; CS rise takes priority over any same-cycle SCK edge.

## Timing
- Reset values: `spi_miso`=0, `word_sent`=0, `tx_busy`=0, `word_idx`=0, `bit_cnt`=0, shift register 0, all `snap_*`=0, state IDLE.
- Frame-start latency: bit 15 is on `spi_miso` within `SYNC_STAGES`+2 `clk50M` cycles of the CS fall (4 cycles at default). The master waits at least 100 ns before the first SCK rise.
- Each SCK phase (high or low) lasts at least `SYNC_STAGES`+2 `clk50M` cycles, i.e. SCK ≤ 6.25 MHz at default.
- `spi_miso` updates `SYNC_STAGES`+1 cycles after the physical SCK fall. It is stable before the next physical SCK rise under the constraint above.
- `word_sent` fires `SYNC_STAGES`+1 cycles after the physical 16th SCK rise and lasts exactly one cycle.
- `rst` asserted mid-frame clears everything immediately. After release, the block waits in IDLE for a fresh CS fall; a frame already in progress is ignored.

## Configuration
- `SPI_STATUS_TX_CRC_EN` defined:
  - Sequence is W0..W3, `word_idx` wraps 3→0.
  - W3 = `{8'h13, d0 ^ d1 ^ d2}`, where dN is the low byte of WN.
- Undefined: sequence is W0..W2, `word_idx` wraps 2→0, and no W3 logic exists.

## Test plan
- Status `angle_current`=`angle_target`=1234, `m_en`=1, `dir`=0, `dev_state`=1; three 16-clock frames → MISO words 0x109A, 0x115A, 0x129A, with one `word_sent` per frame.
- Same status with `SPI_STATUS_TX_CRC_EN` defined; four frames → 0x109A, 0x115A, 0x129A, 0x135A; a fifth frame returns 0x10xx from a new snapshot.
- Change `angle_target` to 0 after the W0 frame → W1 still 0x115A and W2 still 0x129A; the next W0 frame reflects the new value.
- Raise CS after 9 SCK rises during W1 → no `word_sent`; the next frame resends 0x115A.
- 20 SCK clocks in one frame → 16 data bits, then MISO=0; a single `word_sent`; `word_idx` advances by 1.
- Assert `rst` mid-W2 → `spi_miso`=0, `tx_busy`=0 at once; the next frame after release sends W0.
